// File: rtl/fsmc_slave_ctrl.sv
// fsmc_slave_ctrl: sequences FSMC host transactions onto a set of slaves.
// The one-hot bus chip-select is turned into per-slave write strobes and
// read request/acknowledge handshakes. The selected slave's read data is
// returned to the host. A read that is not acknowledged in time returns a
// default word and raises an error pulse, which is counted in a saturating
// error counter.
`timescale 1ns/1ps
module fsmc_slave_ctrl #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    CS_WIDTH       = 2,
    parameter int                    TIMEOUT_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = 16'hDEAD
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [(2**CS_WIDTH)-1:0]         bus_cs,
    input  logic                             bus_state,
    input  logic [DATA_WIDTH-1:0]            bus_wdata,
    output logic [DATA_WIDTH-1:0]            bus_rdata,
    output logic [(2**CS_WIDTH)-1:0]         slv_wr_stb,
    output logic [DATA_WIDTH-1:0]            slv_wdata,
    output logic [(2**CS_WIDTH)-1:0]         slv_rd_req,
    input  logic [(2**CS_WIDTH)-1:0]         slv_rd_ack,
    input  logic [(2**CS_WIDTH)*DATA_WIDTH-1:0] slv_rd_data,
    output logic                             err_timeout,
    output logic [7:0]                       err_cnt,
    output logic                             busy
);

    localparam int NS = 2**CS_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_REQ  = 2'd2,
        RD_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_nx;
    logic [NS-1:0]         cs_prev;
    logic [CS_WIDTH-1:0]   sel_q, sel_nx, sel_in;
    logic [TW-1:0]         tmo_cnt, tmo_nx;
    logic [NS-1:0]         req_nx, stb_nx;
    logic [DATA_WIDTH-1:0] rdata_nx, wdata_nx;
    logic                  err_nx;
    logic                  start, cs_change;
    logic [DATA_WIDTH-1:0] rd_word [NS];

    // Index of the lowest set bit; a multi-bit select resolves to the lowest slave.
    function automatic logic [CS_WIDTH-1:0] lowest_sel(input logic [NS-1:0] cs);
        logic [CS_WIDTH-1:0] r;
        r = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (cs[i]) r = CS_WIDTH'(i);
        end
        return r;
    endfunction

    function automatic logic [NS-1:0] onehot(input logic [CS_WIDTH-1:0] s);
        logic [NS-1:0] one;
        one = NS'(1);
        return one << s;
    endfunction

    // Error counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Unpack the slave read-data bus into one word per slave.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            rd_word[i] = slv_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign start     = (cs_prev == '0) && (bus_cs != '0);
    assign cs_change = (bus_cs != '0) && (bus_cs != cs_prev);
    assign sel_in    = lowest_sel(bus_cs);
    assign busy      = (state_q != IDLE);

    // Previous chip-select; also tracked during reset so a select held across
    // reset release is not mistaken for a new transaction.
    always_ff @(posedge clk) begin
        cs_prev <= bus_cs;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nx;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nx = state_q;
        sel_nx   = sel_q;
        req_nx   = slv_rd_req;
        tmo_nx   = tmo_cnt;
        rdata_nx = bus_rdata;
        wdata_nx = slv_wdata;
        stb_nx   = '0;
        err_nx   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_nx = sel_in;
                    if (bus_state) begin
                        req_nx   = onehot(sel_in);
                        tmo_nx   = '0;
                        state_nx = RD_REQ;
                    end else begin
                        state_nx = WR_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (bus_cs == '0) begin
                    // Write data is valid on the same edge the select clears.
                    wdata_nx = bus_wdata;
                    stb_nx   = onehot(sel_q);
                    state_nx = IDLE;
                end else if (cs_change) begin
                    // Host moved to another slave: drop this write and restart.
                    sel_nx = sel_in;
                    if (bus_state) begin
                        req_nx   = onehot(sel_in);
                        tmo_nx   = '0;
                        state_nx = RD_REQ;
                    end else begin
                        state_nx = WR_WAIT;
                    end
                end
            end
            RD_REQ: begin
                tmo_nx = tmo_cnt + 1'b1;
                if (slv_rd_ack[sel_q]) begin
                    // Ack wins over a timeout landing on the same cycle.
                    rdata_nx = rd_word[sel_q];
                    req_nx   = '0;
                    state_nx = RD_HOLD;
                end else if (tmo_cnt == TMO_LAST) begin
                    rdata_nx = DEFAULT_RDATA;
                    req_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = RD_HOLD;
                end else if (bus_cs == '0) begin
                    // Host gave up on the read; keep the previous read data.
                    req_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            RD_HOLD: begin
                if (bus_cs == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and transaction context.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q       <= '0;
            tmo_cnt     <= '0;
            slv_rd_req  <= '0;
            slv_wr_stb  <= '0;
            slv_wdata   <= '0;
            bus_rdata   <= '0;
            err_timeout <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            sel_q       <= sel_nx;
            tmo_cnt     <= tmo_nx;
            slv_rd_req  <= req_nx;
            slv_wr_stb  <= stb_nx;
            slv_wdata   <= wdata_nx;
            bus_rdata   <= rdata_nx;
            err_timeout <= err_nx;
            if (err_nx) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule
